// File: rtl/dht_responder.sv
// Single-wire humidity/temperature sensor responder: answers a host start pulse
// with a response preamble and a {humid, humid_frac, temp, temp_frac, checksum} frame.
module dht_responder #(
  parameter int MAIN_CLK     = 27_000_000,
  parameter int DATA_BITS    = 8,
  parameter int START_MIN_US = 18000
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [DATA_BITS-1:0] in_humid,
  input  logic [DATA_BITS-1:0] in_humid_frac,
  input  logic [DATA_BITS-1:0] in_temp,
  input  logic [DATA_BITS-1:0] in_temp_frac,
  inout  wire                  inout_dat,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_error
);

  localparam int DIV_RAW    = MAIN_CLK / 1_000_000;
  localparam int DIV        = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int US_MAX     = (START_MIN_US > 127) ? START_MIN_US : 127;
  localparam int US_W       = $clog2(US_MAX + 2);
  localparam int FRAME_BITS = 5 * DATA_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int LOW_LIM    = 2 * DIV;
  localparam int LOW_W      = $clog2(LOW_LIM + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [US_W-1:0]  START_MIN = US_W'(START_MIN_US);
  localparam logic [US_W-1:0]  T_DELAY   = US_W'(30 - 1);
  localparam logic [US_W-1:0]  T_RESP    = US_W'(80 - 1);
  localparam logic [US_W-1:0]  T_BIT_LOW = US_W'(50 - 1);
  localparam logic [US_W-1:0]  T_ZERO    = US_W'(27 - 1);
  localparam logic [US_W-1:0]  T_ONE     = US_W'(70 - 1);
  localparam logic [US_W-1:0]  T_END     = US_W'(50 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [LOW_W-1:0] LOW_LAST  = LOW_W'(LOW_LIM - 1);

  typedef enum logic [2:0] {
    IDLE, START_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [US_W-1:0]         us_q, us_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [1:0]              blank_q, blank_d;
  logic [LOW_W-1:0]        low_cnt_q, low_cnt_d;
  logic                    drive_low_q, drive_low_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                    line_s, fall, rise, tick, enter;
  logic [DATA_BITS-1:0]    csum;

  function automatic logic [US_W-1:0] sat_inc(input logic [US_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign line_s = sync2_q;
  assign fall   = prev_q & ~line_s;
  assign rise   = ~prev_q & line_s;
  assign tick   = (div_q == DIV_LAST);
  assign csum   = in_humid + in_humid_frac + in_temp + in_temp_frac;

  always_comb begin
    sync1_d   = inout_dat;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    us_d      = tick ? sat_inc(us_q) : us_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    blank_d   = blank_q;
    low_cnt_d = low_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    enter     = 1'b0;

    case (state_q)
      IDLE: if (fall) begin
        state_d = START_LOW;
        enter   = 1'b1;
      end
      START_LOW: if (rise) begin
        enter = 1'b1;
        if (us_q >= START_MIN) begin
          state_d   = RESP_DELAY;
          shift_d   = {in_humid, in_humid_frac, in_temp, in_temp_frac, csum};
          bit_cnt_d = '0;
          busy_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RESP_DELAY: if (tick && us_q == T_DELAY) begin
        state_d = RESP_LOW;
        enter   = 1'b1;
      end
      RESP_LOW: if (tick && us_q == T_RESP) begin
        state_d = RESP_HIGH;
        enter   = 1'b1;
      end
      RESP_HIGH: if (tick && us_q == T_RESP) begin
        state_d = BIT_LOW;
        enter   = 1'b1;
      end
      BIT_LOW: if (tick && us_q == T_BIT_LOW) begin
        state_d = BIT_HIGH;
        enter   = 1'b1;
      end
      BIT_HIGH: if (tick && us_q == (shift_q[FRAME_BITS-1] ? T_ONE : T_ZERO)) begin
        enter   = 1'b1;
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          state_d = END_LOW;
        end else begin
          state_d   = BIT_LOW;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      END_LOW: if (tick && us_q == T_END) begin
        state_d = IDLE;
        enter   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        enter   = 1'b1;
      end
    endcase

    // The first two cycles after release still show our own low through the synchronizer.
    if (state_q == RESP_HIGH || state_q == BIT_HIGH) begin
      if (blank_q != 2'd0) begin
        blank_d = blank_q - 1'b1;
      end else if (!line_s) begin
        low_cnt_d = low_cnt_q + 1'b1;
        if (low_cnt_q == LOW_LAST) begin
          state_d = IDLE;
          enter   = 1'b1;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end else begin
        low_cnt_d = '0;
      end
    end

    // Every state restarts the prescaler so durations are whole microseconds.
    if (enter) begin
      div_d     = '0;
      us_d      = '0;
      blank_d   = 2'd2;
      low_cnt_d = '0;
    end

    drive_low_d = (state_d == RESP_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      div_q       <= '0;
      us_q        <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      blank_q     <= '0;
      low_cnt_q   <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      div_q       <= div_d;
      us_q        <= us_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      blank_q     <= blank_d;
      low_cnt_q   <= low_cnt_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign inout_dat = drive_low_q ? 1'b0 : 1'bz;
  assign out_busy  = busy_q;
  assign out_done  = done_q;
  assign out_error = error_q;

endmodule
